// File: rtl/ps2_note_key_tracker.sv
// PS/2 set-2 note key tracker: decodes make/break/extended scan sequences
// and keeps a last-pressed-priority stack of held note keys.
module ps2_note_key_tracker #(
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic                             clk,
  input  logic                             resetn,
  input  logic [7:0]                       ps2_byte,
  input  logic                             ps2_byte_valid,
  output logic [7:0]                       note_code,
  output logic                             note_active,
  output logic                             note_on,
  output logic                             note_off,
  output logic [$clog2(STACK_DEPTH+1)-1:0] held_count
);

  localparam int unsigned CW = $clog2(STACK_DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StBreak, StExt, StExtBreak} state_e;

  state_e        r_state;
  logic [7:0]    r_stack [STACK_DEPTH];  // index 0 is the most recently pressed key
  logic [CW-1:0] r_count;

  logic [7:0]    w_stack_d [STACK_DEPTH];
  logic [CW-1:0] w_count_d;
  logic          w_on_d;
  logic          w_off_d;
  logic          w_make;
  logic          w_break;
  logic          w_clear;
  logic          w_hit;
  logic [CW-1:0] w_hit_idx;

  function automatic logic is_note(input logic [7:0] c);
    logic r;
    case (c)
      8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C,
      8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B,
      8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A: r = 1'b1;
      default:                                         r = 1'b0;
    endcase
    return r;
  endfunction

  assign w_make  = ps2_byte_valid && (r_state == StIdle) && is_note(ps2_byte);
  assign w_break = ps2_byte_valid && (r_state == StBreak);
  assign w_clear = ps2_byte_valid && (r_state == StIdle) && (ps2_byte == 8'hAA);

  assign held_count = r_count;

  // Locate the incoming byte among the valid stack entries.
  always_comb begin
    w_hit     = 1'b0;
    w_hit_idx = '0;
    for (int i = 0; i < int'(STACK_DEPTH); i++) begin
      if (!w_hit && (CW'(i) < r_count) && (r_stack[i] == ps2_byte)) begin
        w_hit     = 1'b1;
        w_hit_idx = CW'(i);
      end
    end
  end

  // Next stack contents, occupancy and pulse requests for this byte.
  always_comb begin
    w_stack_d = r_stack;
    w_count_d = r_count;
    w_on_d    = 1'b0;
    w_off_d   = 1'b0;
    if (w_make && !w_hit) begin
      // Shifting down naturally drops the oldest entry when full.
      w_stack_d[0] = ps2_byte;
      for (int i = 1; i < int'(STACK_DEPTH); i++) begin
        w_stack_d[i] = r_stack[i-1];
      end
      if (r_count != CW'(STACK_DEPTH)) begin
        w_count_d = r_count + 1'b1;
      end
      w_on_d = 1'b1;
    end else if (w_break && w_hit) begin
      for (int i = 0; i < int'(STACK_DEPTH) - 1; i++) begin
        if (CW'(i) >= w_hit_idx) begin
          w_stack_d[i] = r_stack[i+1];
        end
      end
      w_stack_d[STACK_DEPTH-1] = 8'h00;
      w_count_d = r_count - 1'b1;
      if (w_count_d == '0) begin
        w_off_d = 1'b1;
      end else if (w_hit_idx == '0) begin
        w_on_d = 1'b1;  // top released: retrigger on the key below
      end
    end else if (w_clear) begin
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        w_stack_d[i] = 8'h00;
      end
      w_count_d = '0;
      w_off_d   = (r_count != '0);
    end
  end

  // Decoder FSM plus registered stack and outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_count     <= '0;
      note_code   <= 8'h00;
      note_active <= 1'b0;
      note_on     <= 1'b0;
      note_off    <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        r_stack[i] <= 8'h00;
      end
    end else begin
      r_stack     <= w_stack_d;
      r_count     <= w_count_d;
      note_on     <= w_on_d;
      note_off    <= w_off_d;
      note_active <= (w_count_d != '0);
      note_code   <= (w_count_d != '0) ? w_stack_d[0] : 8'h00;
      if (ps2_byte_valid) begin
        case (r_state)
          StIdle: begin
            if (ps2_byte == 8'hF0)      r_state <= StBreak;
            else if (ps2_byte == 8'hE0) r_state <= StExt;
            else                        r_state <= StIdle;
          end
          StBreak: r_state <= StIdle;
          StExt: begin
            if (ps2_byte == 8'hF0) r_state <= StExtBreak;
            else                   r_state <= StIdle;
          end
          StExtBreak: r_state <= StIdle;
          default:    r_state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ps2_note_key_tracker.sv
// Scoreboard bench for ps2_note_key_tracker: each driven byte pushes its
// expected post-byte outputs; a monitor pops and compares one cycle later.
module tb_ps2_note_key_tracker;

  logic       clk;
  logic       resetn;
  logic [7:0] ps2_byte;
  logic       ps2_byte_valid;
  logic [7:0] note_code;
  logic       note_active;
  logic       note_on;
  logic       note_off;
  logic [2:0] held_count;

  typedef struct packed {
    logic [7:0] b;
    logic [7:0] code;
    logic       act;
    logic       on;
    logic       off;
    logic [2:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   step = 0;

  ps2_note_key_tracker #(.STACK_DEPTH(4)) dut (
    .clk           (clk),
    .resetn        (resetn),
    .ps2_byte      (ps2_byte),
    .ps2_byte_valid(ps2_byte_valid),
    .note_code     (note_code),
    .note_active   (note_active),
    .note_on       (note_on),
    .note_off      (note_off),
    .held_count    (held_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: compare after each sampled byte; pulses must be low otherwise.
  always @(posedge clk) begin
    exp_t e;
    if (resetn && ps2_byte_valid) begin
      #1;
      step++;
      tests_run++;
      if (sb.size() == 0) begin
        tests_failed++;
        $display("FAIL step%0d: byte sampled with empty scoreboard", step);
      end else begin
        e = sb.pop_front();
        if ({note_code, note_active, note_on, note_off, held_count} !==
            {e.code, e.act, e.on, e.off, e.cnt}) begin
          tests_failed++;
          $display("FAIL step%0d byte %h: got code=%h act=%b on=%b off=%b cnt=%0d, expected code=%h act=%b on=%b off=%b cnt=%0d",
                   step, e.b, note_code, note_active, note_on, note_off, held_count,
                   e.code, e.act, e.on, e.off, e.cnt);
        end
      end
    end else if (resetn) begin
      #1;
      tests_run++;
      if ({note_on, note_off} !== 2'b00) begin
        tests_failed++;
        $display("FAIL idle_pulse: got on=%b off=%b, expected on=0 off=0", note_on, note_off);
      end
    end
  end

  task automatic send(input logic [7:0] b, input logic [7:0] code, input logic act,
                      input logic on, input logic off, input logic [2:0] cnt);
    @(negedge clk);
    ps2_byte       = b;
    ps2_byte_valid = 1'b1;
    sb.push_back('{b: b, code: code, act: act, on: on, off: off, cnt: cnt});
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    ps2_byte_valid = 1'b0;
    ps2_byte       = 8'h00;
    repeat (n) @(posedge clk);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    ps2_byte_valid = 1'b0;
    resetn = 1'b0;
    #2;
    tests_run++;
    if ({note_code, note_active, note_on, note_off, held_count} !== 15'd0) begin
      tests_failed++;
      $display("FAIL reset_values: got code=%h act=%b on=%b off=%b cnt=%0d, expected all 0",
               note_code, note_active, note_on, note_off, held_count);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    idle(2);
  endtask

  task automatic test_basic();
    send(8'h1C, 8'h1C, 1, 1, 0, 1);
    idle(2);
    send(8'hF0, 8'h1C, 1, 0, 0, 1);
    send(8'h1C, 8'h00, 0, 0, 1, 0);
    idle(2);
  endtask

  task automatic test_typematic();
    send(8'h15, 8'h15, 1, 1, 0, 1);
    send(8'h15, 8'h15, 1, 0, 0, 1);
    send(8'h15, 8'h15, 1, 0, 0, 1);
    send(8'hF0, 8'h15, 1, 0, 0, 1);
    send(8'h15, 8'h00, 0, 0, 1, 0);
    idle(2);
  endtask

  task automatic test_retrigger();
    send(8'h15, 8'h15, 1, 1, 0, 1);
    send(8'h1D, 8'h1D, 1, 1, 0, 2);
    send(8'h24, 8'h24, 1, 1, 0, 3);
    send(8'hF0, 8'h24, 1, 0, 0, 3);
    send(8'h24, 8'h1D, 1, 1, 0, 2);
    send(8'hF0, 8'h1D, 1, 0, 0, 2);
    send(8'h15, 8'h1D, 1, 0, 0, 1);
    send(8'hF0, 8'h1D, 1, 0, 0, 1);
    send(8'h1D, 8'h00, 0, 0, 1, 0);
    idle(2);
  endtask

  task automatic test_evict();
    send(8'h15, 8'h15, 1, 1, 0, 1);
    send(8'h1D, 8'h1D, 1, 1, 0, 2);
    send(8'h24, 8'h24, 1, 1, 0, 3);
    send(8'h2D, 8'h2D, 1, 1, 0, 4);
    send(8'h2C, 8'h2C, 1, 1, 0, 4);
    send(8'hF0, 8'h2C, 1, 0, 0, 4);
    send(8'h2C, 8'h2D, 1, 1, 0, 3);
    send(8'hF0, 8'h2D, 1, 0, 0, 3);
    send(8'h2D, 8'h24, 1, 1, 0, 2);
    send(8'hF0, 8'h24, 1, 0, 0, 2);
    send(8'h24, 8'h1D, 1, 1, 0, 1);
    send(8'hF0, 8'h1D, 1, 0, 0, 1);
    send(8'h1D, 8'h00, 0, 0, 1, 0);
    send(8'hF0, 8'h00, 0, 0, 0, 0);
    send(8'h15, 8'h00, 0, 0, 0, 0);
    idle(2);
  endtask

  task automatic test_extended();
    send(8'h1C, 8'h1C, 1, 1, 0, 1);
    send(8'hE0, 8'h1C, 1, 0, 0, 1);
    send(8'hF0, 8'h1C, 1, 0, 0, 1);
    send(8'h1C, 8'h1C, 1, 0, 0, 1);
    send(8'hE0, 8'h1C, 1, 0, 0, 1);
    send(8'h75, 8'h1C, 1, 0, 0, 1);
    send(8'hE0, 8'h1C, 1, 0, 0, 1);
    send(8'h1D, 8'h1C, 1, 0, 0, 1);
    send(8'hF0, 8'h1C, 1, 0, 0, 1);
    send(8'h1C, 8'h00, 0, 0, 1, 0);
    idle(2);
  endtask

  task automatic test_non_note();
    send(8'h76, 8'h00, 0, 0, 0, 0);
    send(8'h2B, 8'h2B, 1, 1, 0, 1);
    send(8'h29, 8'h2B, 1, 0, 0, 1);
    send(8'hF0, 8'h2B, 1, 0, 0, 1);
    send(8'h29, 8'h2B, 1, 0, 0, 1);
    idle(1);
  endtask

  task automatic test_clear();
    send(8'h1D, 8'h1D, 1, 1, 0, 2);
    send(8'hAA, 8'h00, 0, 0, 1, 0);
    send(8'hAA, 8'h00, 0, 0, 0, 0);
    send(8'h3A, 8'h3A, 1, 1, 0, 1);
    send(8'hAA, 8'h00, 0, 0, 1, 0);
    idle(2);
  endtask

  task automatic test_reset_mid_sequence();
    send(8'h3A, 8'h3A, 1, 1, 0, 1);
    send(8'hF0, 8'h3A, 1, 0, 0, 1);
    pulse_reset();
    send(8'h3A, 8'h3A, 1, 1, 0, 1);
    send(8'h31, 8'h31, 1, 1, 0, 2);
    idle(2);
  endtask

  task automatic test_back_to_back();
    send(8'hAA, 8'h00, 0, 0, 1, 0);
    send(8'h21, 8'h21, 1, 1, 0, 1);
    send(8'h22, 8'h22, 1, 1, 0, 2);
    send(8'hF0, 8'h22, 1, 0, 0, 2);
    send(8'h21, 8'h22, 1, 0, 0, 1);
    send(8'hF0, 8'h22, 1, 0, 0, 1);
    send(8'h22, 8'h00, 0, 0, 1, 0);
    send(8'h32, 8'h32, 1, 1, 0, 1);
    idle(2);
  endtask

  initial begin
    resetn         = 1'b0;
    ps2_byte       = 8'h00;
    ps2_byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    test_reset();
    test_basic();
    test_typematic();
    test_retrigger();
    test_evict();
    test_extended();
    test_non_note();
    test_clear();
    test_reset_mid_sequence();
    test_back_to_back();
    idle(2);
    tests_run++;
    if (sb.size() != 0) begin
      tests_failed++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
